// File: rtl/onchip_memory_arbiter.sv
// onchip_memory_arbiter
// Two-master round-robin front end for a single-port on-chip RAM. One access
// per clock is granted combinationally, out-of-range addresses are absorbed
// without touching the memory, and read data is returned through a fixed
// latency tag pipeline that routes it back to the requesting master.
module onchip_memory_arbiter #(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 32,
   parameter int DEPTH        = 40000,
   parameter int READ_LATENCY = 1
) (
   input  logic                clk,
   input  logic                reset_n,

   input  logic [ADDR_W-1:0]   m0_address,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [DATA_W-1:0]   m0_writedata,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   output logic                m0_readdatavalid,

   input  logic [ADDR_W-1:0]   m1_address,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W-1:0]   m1_writedata,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic                m1_readdatavalid,

   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W/8-1:0] mem_byteenable,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [DATA_W-1:0]   mem_writedata,
   output logic                mem_clken,
   input  logic [DATA_W-1:0]   mem_readdata,

   output logic                oor_error
);

   localparam int BE_W = DATA_W / 8;

   logic                    req0;
   logic                    req1;
   logic                    grant0;
   logic                    grant1;
   logic                    accept;
   logic                    sel;
   logic                    last_grant;
   logic                    acc_write;
   logic                    acc_read;
   logic                    acc_oor;
   logic [ADDR_W-1:0]       acc_address;
   logic [BE_W-1:0]         acc_byteenable;
   logic [DATA_W-1:0]       acc_writedata;
   logic                    oor_pulse;
   logic                    ret_valid;
   logic [DATA_W-1:0]       ret_data;
   logic [READ_LATENCY-1:0] pipe_valid;
   logic [READ_LATENCY-1:0] pipe_id;
   logic [READ_LATENCY-1:0] pipe_oor;

   // Request decode and round-robin grant; last_grant names the master that
   // won most recently, so under contention the other one wins. Nothing is
   // granted while reset is held.
   always_comb begin
      req0   = m0_read | m0_write;
      req1   = m1_read | m1_write;
      grant0 = reset_n & req0 & (~req1 | last_grant);
      grant1 = reset_n & req1 & (~req0 | ~last_grant);
      accept = grant0 | grant1;
      sel    = grant1;
   end

   // Select the granted master's access; write takes priority over read.
   always_comb begin
      if (sel) begin
         acc_address    = m1_address;
         acc_byteenable = m1_byteenable;
         acc_writedata  = m1_writedata;
         acc_write      = accept & m1_write;
      end else begin
         acc_address    = m0_address;
         acc_byteenable = m0_byteenable;
         acc_writedata  = m0_writedata;
         acc_write      = accept & m0_write;
      end
      acc_read = accept & ~acc_write;
      acc_oor  = (33'(acc_address) >= 33'(DEPTH));
   end

   // Drive the shared memory port and the per-master handshakes; an
   // out-of-range access is accepted but never reaches the memory.
   always_comb begin
      m0_waitrequest = ~grant0;
      m1_waitrequest = ~grant1;
      mem_address    = acc_address;
      mem_byteenable = acc_byteenable;
      mem_writedata  = acc_writedata;
      mem_chipselect = accept & ~acc_oor;
      mem_write      = acc_write & ~acc_oor;
      mem_clken      = reset_n;
      oor_error      = reset_n & oor_pulse;
   end

   // Round-robin history and the delayed out-of-range strobe.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         last_grant <= 1'b1;
         oor_pulse  <= 1'b0;
      end else begin
         if (accept) begin
            last_grant <= sel;
         end
         oor_pulse <= accept & acc_oor;
      end
   end

   // Read-return tag pipeline, one stage per cycle of memory latency.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pipe_valid <= '0;
         pipe_id    <= '0;
         pipe_oor   <= '0;
      end else begin
         pipe_valid[0] <= acc_read;
         pipe_id[0]    <= sel;
         pipe_oor[0]   <= acc_oor;
         for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_id[i]    <= pipe_id[i-1];
            pipe_oor[i]   <= pipe_oor[i-1];
         end
      end
   end

   // Route the returning word to its owner; out-of-range reads return zero.
   always_comb begin
      ret_valid        = reset_n & pipe_valid[READ_LATENCY-1];
      ret_data         = pipe_oor[READ_LATENCY-1] ? '0 : mem_readdata;
      m0_readdatavalid = ret_valid & ~pipe_id[READ_LATENCY-1];
      m1_readdatavalid = ret_valid & pipe_id[READ_LATENCY-1];
      m0_readdata      = ret_data;
      m1_readdata      = ret_data;
   end

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Testbench for onchip_memory_arbiter: two instances (read latency 1 and 3)
// share one stimulus stream, each backed by its own behavioural RAM, and a
// transaction-level model predicts grants, memory port activity and returns.
module tb_onchip_memory_arbiter;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 40000;
   localparam int LAT_A  = 1;
   localparam int LAT_B  = 3;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic [ADDR_W-1:0] m_address [2];
   logic [3:0]        m_byteenable [2];
   logic              m_read [2];
   logic              m_write [2];
   logic [31:0]       m_writedata [2];

   logic [1:0][1:0]        waitr;
   logic [1:0][1:0]        rdv;
   logic [1:0][1:0][31:0]  rdata;
   logic [1:0][ADDR_W-1:0] mem_address;
   logic [1:0][3:0]        mem_be;
   logic [1:0]             mem_cs;
   logic [1:0]             mem_wr;
   logic [1:0]             mem_clken;
   logic [1:0]             oor_err;
   logic [1:0][31:0]       mem_wd;
   logic [1:0][31:0]       mem_rd;

   int checks = 0;
   int errors = 0;

   onchip_memory_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .READ_LATENCY(LAT_A)) dut_a (
      .clk(clk), .reset_n(reset_n),
      .m0_address(m_address[0]), .m0_byteenable(m_byteenable[0]), .m0_read(m_read[0]),
      .m0_write(m_write[0]), .m0_writedata(m_writedata[0]), .m0_waitrequest(waitr[0][0]),
      .m0_readdata(rdata[0][0]), .m0_readdatavalid(rdv[0][0]),
      .m1_address(m_address[1]), .m1_byteenable(m_byteenable[1]), .m1_read(m_read[1]),
      .m1_write(m_write[1]), .m1_writedata(m_writedata[1]), .m1_waitrequest(waitr[0][1]),
      .m1_readdata(rdata[0][1]), .m1_readdatavalid(rdv[0][1]),
      .mem_address(mem_address[0]), .mem_byteenable(mem_be[0]), .mem_chipselect(mem_cs[0]),
      .mem_write(mem_wr[0]), .mem_writedata(mem_wd[0]), .mem_clken(mem_clken[0]),
      .mem_readdata(mem_rd[0]), .oor_error(oor_err[0]));

   onchip_memory_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .READ_LATENCY(LAT_B)) dut_b (
      .clk(clk), .reset_n(reset_n),
      .m0_address(m_address[0]), .m0_byteenable(m_byteenable[0]), .m0_read(m_read[0]),
      .m0_write(m_write[0]), .m0_writedata(m_writedata[0]), .m0_waitrequest(waitr[1][0]),
      .m0_readdata(rdata[1][0]), .m0_readdatavalid(rdv[1][0]),
      .m1_address(m_address[1]), .m1_byteenable(m_byteenable[1]), .m1_read(m_read[1]),
      .m1_write(m_write[1]), .m1_writedata(m_writedata[1]), .m1_waitrequest(waitr[1][1]),
      .m1_readdata(rdata[1][1]), .m1_readdatavalid(rdv[1][1]),
      .mem_address(mem_address[1]), .mem_byteenable(mem_be[1]), .mem_chipselect(mem_cs[1]),
      .mem_write(mem_wr[1]), .mem_writedata(mem_wd[1]), .mem_clken(mem_clken[1]),
      .mem_readdata(mem_rd[1]), .oor_error(oor_err[1]));

   function automatic logic [31:0] init_word(input int i);
      return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
   endfunction

   // Behavioural single-port RAMs with registered output and extra delay.
   for (genvar d = 0; d < 2; d++) begin : g_mem
      localparam int LAT = (d == 0) ? LAT_A : LAT_B;
      logic [31:0] store [DEPTH];
      logic [31:0] rpipe [3];
      logic [31:0] word;
      initial begin
         for (int i = 0; i < DEPTH; i++) store[i] = init_word(i);
      end
      always @(posedge clk) begin
         if (mem_clken[d] && mem_cs[d] && (int'(mem_address[d]) < DEPTH)) begin
            word = store[mem_address[d]];
            if (mem_wr[d]) begin
               for (int b = 0; b < 4; b++)
                  if (mem_be[d][b]) word[8*b +: 8] = mem_wd[d][8*b +: 8];
               store[mem_address[d]] <= word;
            end else begin
               rpipe[0] <= word;
            end
         end
         rpipe[1] <= rpipe[0];
         rpipe[2] <= rpipe[1];
      end
      assign mem_rd[d] = rpipe[LAT-1];
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
      end
   endtask

   // Transaction-level model state.
   logic [31:0] ref_mem [DEPTH];
   int          cyc = 0;
   int          model_last = 1;
   bit          prev_oor = 0;
   bit          evt_valid [8];
   int          evt_id [8];
   logic [31:0] evt_data [8];
   bit          acc [2];

   // Observation records for the directed literal checks.
   int          rdv_count [2][2];
   logic [31:0] last_rdata [2][2];
   int          last_rdv_cyc [2][2];
   int          oor_count [2];
   int          rdv_q [$];

   int          win, lat, slot;
   bit          granted, a_oor, a_wr, exp_v;
   logic [ADDR_W-1:0] a_addr;
   logic [31:0] nw;
   string       tag;

   // Per-cycle prediction and comparison against both instances.
   always @(negedge clk) begin
      cyc = cyc + 1;
      win = -1;
      if (reset_n) begin
         if ((m_read[0] || m_write[0]) && (m_read[1] || m_write[1])) win = (model_last == 0) ? 1 : 0;
         else if (m_read[0] || m_write[0]) win = 0;
         else if (m_read[1] || m_write[1]) win = 1;
      end
      granted = (win >= 0);
      a_addr = granted ? m_address[win] : '0;
      a_oor  = granted && (int'(a_addr) >= DEPTH);
      a_wr   = granted && m_write[win];
      for (int d = 0; d < 2; d++) begin
         tag = (d == 0) ? "A" : "B";
         lat = (d == 0) ? LAT_A : LAT_B;
         checkOutput({tag, ".wait0"}, 32'(waitr[d][0]), (win == 0) ? 0 : 1);
         checkOutput({tag, ".wait1"}, 32'(waitr[d][1]), (win == 1) ? 0 : 1);
         checkOutput({tag, ".clken"}, 32'(mem_clken[d]), 32'(reset_n));
         checkOutput({tag, ".oor_error"}, 32'(oor_err[d]), 32'(reset_n && prev_oor));
         checkOutput({tag, ".chipselect"}, 32'(mem_cs[d]), 32'(granted && !a_oor));
         checkOutput({tag, ".mem_write"}, 32'(mem_wr[d]), 32'(a_wr && !a_oor));
         if (granted && !a_oor) begin
            checkOutput({tag, ".mem_address"}, 32'(mem_address[d]), 32'(a_addr));
            if (a_wr) begin
               checkOutput({tag, ".mem_be"}, 32'(mem_be[d]), 32'(m_byteenable[win]));
               checkOutput({tag, ".mem_wdata"}, mem_wd[d], m_writedata[win]);
            end
         end
         slot = (cyc - lat) & 7;
         for (int m = 0; m < 2; m++) begin
            exp_v = reset_n && evt_valid[slot] && (evt_id[slot] == m);
            checkOutput({tag, (m == 0) ? ".rdv0" : ".rdv1"}, 32'(rdv[d][m]), 32'(exp_v));
            if (exp_v) checkOutput({tag, (m == 0) ? ".rdata0" : ".rdata1"}, rdata[d][m], evt_data[slot]);
            if (rdv[d][m]) begin
               rdv_count[d][m]++;
               last_rdata[d][m] = rdata[d][m];
               last_rdv_cyc[d][m] = cyc;
               if (d == 1 && m == 0) rdv_q.push_back(cyc);
            end
         end
         if (oor_err[d]) oor_count[d]++;
      end
      acc[0] = (win == 0);
      acc[1] = (win == 1);
      if (!reset_n) begin
         for (int k = 0; k < 8; k++) evt_valid[k] = 0;
         model_last = 1;
         prev_oor = 0;
      end else begin
         evt_valid[cyc & 7] = granted && !a_wr;
         evt_id[cyc & 7] = win;
         evt_data[cyc & 7] = (granted && !a_oor) ? ref_mem[a_addr] : 32'h0;
         if (a_wr && !a_oor) begin
            nw = ref_mem[a_addr];
            for (int b = 0; b < 4; b++)
               if (m_byteenable[win][b]) nw[8*b +: 8] = m_writedata[win][8*b +: 8];
            ref_mem[a_addr] = nw;
         end
         prev_oor = a_oor;
         if (granted) model_last = win;
      end
   end

   // Issue one transfer from master m, hold it until accepted, then drop it.
   task automatic applyStimulus(input int m, input bit rd, input bit wr, input int addr,
                                input logic [3:0] be, input logic [31:0] data,
                                output int waits, output int acc_at);
      m_read[m] = rd;
      m_write[m] = wr;
      m_address[m] = ADDR_W'(addr);
      m_byteenable[m] = be;
      m_writedata[m] = data;
      acc_at = -1;
      waits = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         #1;
         if (acc[m]) begin
            acc_at = cyc;
            break;
         end
         waits++;
         @(posedge clk);
         #1;
      end
      if (acc_at < 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout master %0d: got no grant expected grant within 50 cycles", m);
      end else begin
         @(posedge clk);
         #1;
      end
      m_read[m] = 1'b0;
      m_write[m] = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic doReset(input int n);
      reset_n = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no completion expected end of run");
      $fatal(1, "[TB] watchdog expired");
   end

   int w, a, ra, base;
   int c0 [3];
   int c1 [3];
   int rc_before [2];

   initial begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
      for (int m = 0; m < 2; m++) begin
         m_read[m] = 0; m_write[m] = 0; m_address[m] = '0;
         m_byteenable[m] = '0; m_writedata[m] = '0;
      end
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Lone m0 write then read-back.
      applyStimulus(0, 0, 1, 16'h0010, 4'hF, 32'hDEADBEEF, w, a);
      checkOutput("t1.write_waits", 32'(w), 0);
      applyStimulus(0, 1, 0, 16'h0010, 4'h0, 32'h0, w, ra);
      checkOutput("t1.read_waits", 32'(w), 0);
      idle(6);
      checkOutput("t1.A.data", last_rdata[0][0], 32'hDEADBEEF);
      checkOutput("t1.B.data", last_rdata[1][0], 32'hDEADBEEF);
      checkOutput("t1.A.latency", 32'(last_rdv_cyc[0][0] - ra), 1);
      checkOutput("t1.B.latency", 32'(last_rdv_cyc[1][0] - ra), 3);
      checkOutput("t1.A.m1_rdv", 32'(rdv_count[0][1]), 0);
      checkOutput("t1.B.m1_rdv", 32'(rdv_count[1][1]), 0);

      // Continuous contention from a fresh reset: m0, m1, m0, ...
      doReset(2);
      fork
         begin
            int w0;
            for (int k = 0; k < 3; k++) applyStimulus(0, 1, 0, 1, 4'h0, 32'h0, w0, c0[k]);
         end
         begin
            int w1;
            for (int k = 0; k < 3; k++) applyStimulus(1, 1, 0, 2, 4'h0, 32'h0, w1, c1[k]);
         end
      join
      for (int k = 0; k < 3; k++) checkOutput("t2.m1_after_m0", 32'(c1[k] - c0[k]), 1);
      checkOutput("t2.m0_period", 32'(c0[1] - c0[0]), 2);
      idle(6);
      checkOutput("t2.A.m0_data", last_rdata[0][0], init_word(1));
      checkOutput("t2.A.m1_data", last_rdata[0][1], init_word(2));

      // Byte-enabled merge by m1.
      applyStimulus(1, 0, 1, 5, 4'hF, 32'hAABBCCDD, w, a);
      applyStimulus(1, 0, 1, 5, 4'b0101, 32'h11223344, w, a);
      applyStimulus(1, 1, 0, 5, 4'h0, 32'h0, w, a);
      idle(6);
      checkOutput("t3.A.merge", last_rdata[0][1], 32'hAA22CC44);
      checkOutput("t3.B.merge", last_rdata[1][1], 32'hAA22CC44);

      // Out-of-range read and write.
      rc_before[0] = oor_count[0];
      rc_before[1] = oor_count[1];
      fork
         begin
            int w0, a0;
            applyStimulus(0, 1, 0, 40000, 4'h0, 32'h0, w0, a0);
         end
         begin
            int w1, a1;
            applyStimulus(1, 0, 1, 65535, 4'hF, 32'h12345678, w1, a1);
         end
      join
      idle(6);
      checkOutput("t4.A.oor_pulses", 32'(oor_count[0] - rc_before[0]), 2);
      checkOutput("t4.B.oor_pulses", 32'(oor_count[1] - rc_before[1]), 2);
      checkOutput("t4.A.zero_data", last_rdata[0][0], 32'h0);
      checkOutput("t4.B.zero_data", last_rdata[1][0], 32'h0);

      // Four back-to-back reads through the latency-3 instance.
      rdv_q.delete();
      applyStimulus(0, 1, 0, 20, 4'h0, 32'h0, w, base);
      for (int k = 21; k < 24; k++) applyStimulus(0, 1, 0, k, 4'h0, 32'h0, w, a);
      idle(6);
      checkOutput("t5.B.count", 32'(rdv_q.size()), 4);
      if (rdv_q.size() == 4)
         for (int k = 0; k < 4; k++) checkOutput("t5.B.pulse_cycle", 32'(rdv_q[k] - base), 32'(3 + k));
      checkOutput("t5.B.last_data", last_rdata[1][0], init_word(23));

      // Reset right after a read is accepted discards it.
      rc_before[0] = rdv_count[0][0];
      rc_before[1] = rdv_count[1][0];
      applyStimulus(0, 1, 0, 7, 4'h0, 32'h0, w, a);
      doReset(2);
      idle(6);
      checkOutput("t6.A.no_return", 32'(rdv_count[0][0] - rc_before[0]), 0);
      checkOutput("t6.B.no_return", 32'(rdv_count[1][0] - rc_before[1]), 0);
      fork
         begin
            int w0;
            applyStimulus(0, 1, 0, 8, 4'h0, 32'h0, w0, c0[0]);
         end
         begin
            int w1;
            applyStimulus(1, 1, 0, 9, 4'h0, 32'h0, w1, c1[0]);
         end
      join
      checkOutput("t6.m0_first", 32'(c1[0] - c0[0]), 1);
      idle(4);

      // Randomized traffic with occasional resets.
      fork
         for (int m = 0; m < 2; m++) begin
            fork
               automatic int mm = m;
               begin
                  int wr_w, wr_a, addr, kind, sel;
                  for (int t = 0; t < 250; t++) begin
                     idle($urandom_range(0, 2));
                     sel = $urandom_range(0, 9);
                     if (sel == 0) addr = $urandom_range(40000, 65535);
                     else if (sel == 1) addr = 39999;
                     else if (sel == 2) addr = 40000;
                     else addr = $urandom_range(0, 31);
                     kind = $urandom_range(0, 2);
                     applyStimulus(mm, kind != 1, kind != 0, addr, 4'($urandom_range(0, 15)),
                                   32'($urandom), wr_w, wr_a);
                  end
               end
            join_none
         end
         begin
            repeat (3) begin
               repeat ($urandom_range(150, 300)) @(posedge clk);
               #1;
               reset_n = 1'b0;
               repeat ($urandom_range(1, 2)) @(posedge clk);
               #1;
               reset_n = 1'b1;
            end
         end
      join
      wait fork;
      idle(8);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
